game_over: RTL and testbench

GAME_OVER -- requirements
Module: game_over

---
 rtl/game_over.sv | 177 +++++++++++++++++
 tb/tb_game_over.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/game_over.sv
// Game-over overlay: shows the sprite for a fixed hold time, then blinks it
// and waits for a fresh restart button press before handing control back.
module game_over_rom (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] row,
  input  logic [7:0] col,
  output logic [7:0] color_data
);

  // Only the low address bits shape the pattern; the rest feed this sink.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{row[4:3], col[7:3]};

  // Checkerboard of transparent cells and opaque cells coloured by position.
  function automatic logic [7:0] rom_word(input logic [4:0] r, input logic [7:0] c);
    if (c[2] ^ r[1]) begin
      return 8'h5D;
    end
    return {r[2:0], c[2:0], 2'b11};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_data <= 8'h00;
    end else begin
      color_data <= rom_word(row, col);
    end
  end

endmodule

module game_over #(
  parameter int          CLK_HZ    = 50000000,
  parameter int          HOLD_SEC  = 3,
  parameter int          SPR_X0    = 375,
  parameter int          SPR_Y0    = 240,
  parameter int          SPR_W     = 178,
  parameter int          SPR_H     = 19,
  parameter logic [7:0]  KEY_COLOR = 8'h5D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       player_dead,
  input  logic       btn_restart,
  output logic       over_active,
  output logic       over_display_on,
  output logic [7:0] rgb,
  output logic       restart_pulse
);

  localparam int          SYNC_LEN   = 2;
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_SEC * CLK_HZ - 1);
  localparam logic [31:0] BLINK_LAST = 32'(CLK_HZ / 2 - 1);
  localparam logic [9:0]  X_LO       = 10'(SPR_X0);
  localparam logic [9:0]  X_HI       = 10'(SPR_X0 + SPR_W);
  localparam logic [9:0]  Y_LO       = 10'(SPR_Y0);
  localparam logic [9:0]  Y_HI       = 10'(SPR_Y0 + SPR_H);

  typedef enum logic [1:0] {IDLE, SHOW, ARMED} state_t;

  state_t      state_reg;
  logic [31:0] hold_cnt_reg;
  logic [31:0] blink_cnt_reg;
  logic        blink_on_reg;
  logic        window_reg;
  logic [7:0]  color_data;
  logic [4:0]  rom_row;
  logic [7:0]  rom_col;
  logic        in_window;

  // Button synchronizer chain; index 0 is the raw pin.
  logic [SYNC_LEN:0] sync_chain;
  logic              btn_prev_reg;
  logic              btn_rise;

  assign sync_chain[0] = btn_restart;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_LEN; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_chain[gi+1] <= 1'b0;
        end else begin
          sync_chain[gi+1] <= sync_chain[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_reg <= 1'b0;
    end else begin
      btn_prev_reg <= sync_chain[SYNC_LEN];
    end
  end

  // A button already held when ARMED is entered shows no rise, so it cannot restart.
  assign btn_rise = sync_chain[SYNC_LEN] & ~btn_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_cnt_reg  <= 32'd0;
      blink_cnt_reg <= 32'd0;
      blink_on_reg  <= 1'b1;
      over_active   <= 1'b0;
      restart_pulse <= 1'b0;
    end else begin
      restart_pulse <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (player_dead) begin
            state_reg    <= SHOW;
            hold_cnt_reg <= 32'd0;
            over_active  <= 1'b1;
          end
        end
        SHOW: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            state_reg     <= ARMED;
            hold_cnt_reg  <= 32'd0;
            blink_cnt_reg <= 32'd0;
            blink_on_reg  <= 1'b1;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 32'd1;
          end
        end
        ARMED: begin
          if (btn_rise) begin
            state_reg     <= IDLE;
            over_active   <= 1'b0;
            restart_pulse <= 1'b1;
            blink_cnt_reg <= 32'd0;
            blink_on_reg  <= 1'b1;
          end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= 32'd0;
            blink_on_reg  <= ~blink_on_reg;
          end else begin
            blink_cnt_reg <= blink_cnt_reg + 32'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Sprite-relative address wraps naturally; out-of-window pixels are masked by window_reg.
  assign rom_col   = 8'(x - X_LO);
  assign rom_row   = 5'(y - Y_LO);
  assign in_window = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);

  game_over_rom u_rom (
    .clk        (clk),
    .rst        (rst),
    .row        (rom_row),
    .col        (rom_col),
    .color_data (color_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_reg <= 1'b0;
    end else begin
      window_reg <= in_window;
    end
  end

  assign rgb             = color_data;
  assign over_display_on = window_reg && (color_data != KEY_COLOR) &&
                           ((state_reg == SHOW) || ((state_reg == ARMED) && blink_on_reg));

endmodule

// File: tb/tb_game_over.sv
// Bench for game_over with a 100 Hz clock and 2 s hold, so the hold is 200
// cycles and the blink half-period is 50 cycles.
module tb_game_over;

  localparam int X0 = 375;
  localparam int Y0 = 240;
  localparam int W  = 178;
  localparam int H  = 19;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic       player_dead = 1'b0;
  logic       btn_restart = 1'b0;
  logic       over_active;
  logic       over_display_on;
  logic [7:0] rgb;
  logic       restart_pulse;

  always #5 clk = ~clk;

  game_over #(.CLK_HZ(100), .HOLD_SEC(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .x               (x),
    .y               (y),
    .player_dead     (player_dead),
    .btn_restart     (btn_restart),
    .over_active     (over_active),
    .over_display_on (over_display_on),
    .rgb             (rgb),
    .restart_pulse   (restart_pulse)
  );

  typedef struct {
    string      name;
    int         t;
    logic       oa;
    logic       rp;
    logic       dsp;
    logic [7:0] rgb;
  } exp_t;

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       vis;
  } pix_t;

  exp_t sb[$];
  pix_t tab[8];
  int   n_checks = 0;
  int   n_fail = 0;

  // Sprite contents: transparent where col bit 2 differs from row bit 1.
  function automatic logic [7:0] rom_model(input logic [9:0] xx, input logic [9:0] yy);
    logic [9:0] dx;
    logic [9:0] dy;
    dx = xx - 10'(X0);
    dy = yy - 10'(Y0);
    if (dx[2] != dy[1]) return 8'h5D;
    return {dy[2:0], dx[2:0], 2'b11};
  endfunction

  // Overlay visible: steady for 200 cycles, then 50 on / 50 off.
  function automatic logic blink_show(input int t);
    if (t < 200) return 1'b1;
    return (((t - 200) / 50) % 2) == 0;
  endfunction

  task automatic chk(input string name, input int t, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name, input int t);
    chk({name, ".over_active"}, t, {7'd0, over_active}, 8'd0);
    chk({name, ".restart_pulse"}, t, {7'd0, restart_pulse}, 8'd0);
    chk({name, ".over_display_on"}, t, {7'd0, over_display_on}, 8'd0);
    chk({name, ".rgb"}, t, rgb, 8'd0);
  endtask

  // One transaction: drive inputs, queue the expected outputs, clock, compare.
  task automatic cycle(input string name, input int t, input logic dead, input logic btn,
                       input int pi, input logic e_oa, input logic e_rp, input logic e_show);
    exp_t e;
    player_dead = dead;
    btn_restart = btn;
    x = tab[pi].px;
    y = tab[pi].py;
    e.name = name;
    e.t    = t;
    e.oa   = e_oa;
    e.rp   = e_rp;
    e.dsp  = e_show && tab[pi].vis;
    e.rgb  = rom_model(tab[pi].px, tab[pi].py);
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    $display("%s t=%0d x=%0d y=%0d oa=%0b rp=%0b dsp=%0b rgb=%0h", e.name, e.t, x, y,
             over_active, restart_pulse, over_display_on, rgb);
    chk({e.name, ".over_active"}, e.t, {7'd0, over_active}, {7'd0, e.oa});
    chk({e.name, ".restart_pulse"}, e.t, {7'd0, restart_pulse}, {7'd0, e.rp});
    chk({e.name, ".over_display_on"}, e.t, {7'd0, over_display_on}, {7'd0, e.dsp});
    chk({e.name, ".rgb"}, e.t, rgb, e.rgb);
  endtask

  initial begin
    tab[0] = '{10'(X0 + 10),    10'(Y0 + 5),     1'b1};
    tab[1] = '{10'(X0),         10'(Y0),         1'b1};
    tab[2] = '{10'(X0 + W),     10'(Y0),         1'b0};
    tab[3] = '{10'(X0),         10'(Y0 - 1),     1'b0};
    tab[4] = '{10'(X0 + W - 1), 10'(Y0 + H - 2), 1'b1};
    tab[5] = '{10'(X0 - 1),     10'(Y0),         1'b0};
    tab[6] = '{10'(X0 + 14),    10'(Y0 + 5),     1'b0};
    tab[7] = '{10'(X0 + 3),     10'(Y0 + H),     1'b0};

    x = tab[0].px;
    y = tab[0].py;
    tick();
    tick();
    check_all_zero("reset", 0);
    rst = 1'b0;

    // Idle: in-window pixel must not be shown.
    for (int i = 0; i < 3; i++) cycle("idle", i, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Run 1: full show/armed/restart sequence.
    cycle("enter", 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    for (int t = 1; t <= 8; t++) cycle("table", t, 1'b0, 1'b0, t - 1, 1'b1, 1'b0, 1'b1);
    for (int t = 9; t <= 320; t++) begin
      logic dead;
      logic btn;
      int   pi;
      dead = (t == 100) || (t == 230) || (t == 302);
      btn  = (t >= 50 && t < 60) || (t >= 150 && t <= 260) || (t >= 300);
      pi   = (t >= 210 && t < 220) ? 6 : 0;
      cycle("run1", t, dead, btn, pi, t < 302, t == 302, (t < 302) && blink_show(t));
    end
    for (int i = 0; i < 5; i++) cycle("gap", i, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Run 2: reset in the middle of the hold.
    for (int t = 0; t <= 120; t++) cycle("run2", t, t == 0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_show", 120);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all_zero("rst_show_hold", i);
    end
    rst = 1'b0;

    // Run 3: fresh full hold after reset, then reset before a pending restart.
    for (int t = 0; t <= 261; t++) cycle("run3", t, t == 0, t >= 260, 0, 1'b1, 1'b0, blink_show(t));
    #2 rst = 1'b1;
    #1 check_all_zero("rst_armed", 261);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all_zero("rst_armed_hold", i);
    end
    rst = 1'b0;
    btn_restart = 1'b0;
    tick();
    chk("post_rst.restart_pulse", 0, {7'd0, restart_pulse}, 8'd0);
    chk("post_rst.over_active", 0, {7'd0, over_active}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
